multi_debounce: RTL and testbench
=================================

Name: multi_debounce

Overview:
- N-channel successor to the single-button debounce/edge-count logic.
- Each channel gets:
  - a 2-FF synchroniser;
  - a symmetric debounce filter (both press and release are filtered);
  - one-cycle press and release pulses;
  - optional auto-repeat while the button is held;
  - a per-channel wrapping event counter.
- Sits between raw board pushbuttons and user logic (LED counters, menu FSMs).

Parameters:
- N, 5: number of button channels.
- DEBOUNCE_CYCLES, 131072: consecutive stable cycles required before the debounced state changes (>=2).
- REPEAT_DELAY, 50000000: cycles from Press to the first Repeat pulse (>=2).
- REPEAT_PERIOD, 10000000: cycles between subsequent Repeat pulses (>=2).
- EVT_W, 8: width of each channel's event counter.

Ports:
- Clk  input  1  system clock, all logic on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Buttons  input  N  raw asynchronous button levels, bit i = channel i.
- RepeatEn  input  1  global auto-repeat enable, synchronous.
- Clear  input  1  synchronous clear of all event counters.
- Debounced  output  N  filtered button levels.
- Press  output  N  1-cycle pulse on a debounced rising edge.
- Release  output  N  1-cycle pulse on a debounced falling edge.
- Repeat  output  N  1-cycle auto-repeat pulse.
- Counts  output  N*EVT_W  event counters; channel i is at [i*EVT_W +: EVT_W].

Behaviour:
- Reset:
  - Rst=1 at an edge zeroes every register: synchronisers, Debounced, debounce counters, repeat counters/phase, Press, Release, Repeat, Counts.
  - Reset mid-debounce or mid-repeat discards all progress.
  - Rst has priority over Clear and over all events.
- Synchroniser: s_i = Buttons[i] delayed 2 Clk edges.
- Debounce filter, per channel, each edge:
  - s_i == Debounced[i]: counter <= 0.
  - Otherwise, counter == DEBOUNCE_CYCLES-1: Debounced[i] <= s_i and counter <= 0.
  - Otherwise: counter++.
  - Any single-cycle agreement restarts the count, so glitches shorter than DEBOUNCE_CYCLES never propagate.
- Debounce latency: a Buttons change sampled at edge E0 and held stable appears on Debounced at edge E0+DEBOUNCE_CYCLES+1.
- Counter width: ceil(log2(DEBOUNCE_CYCLES)); it never exceeds DEBOUNCE_CYCLES-1.
- Press/Release:
  - Registered, updated at the same edge as Debounced.
  - Press[i]=1 exactly during the first cycle Debounced[i] is 1; Release[i]=1 exactly during the first cycle it is 0.
  - Never both high together.
- Repeat, per channel, 2-phase FSM with repeat counter rc:
  - Phase DELAY is the reset state.
  - In the cycle Press[i]=1: rc=0, phase DELAY.
  - Each following cycle with Debounced[i]=1 and RepeatEn=1: rc++.
  - DELAY: Repeat pulse in cycle Press+REPEAT_DELAY, then rc=0 and phase RATE.
  - RATE: a pulse every REPEAT_PERIOD cycles thereafter.
  - Debounced[i]=0 or RepeatEn=0: rc <= 0, phase DELAY, no pulse.
  - Re-asserting RepeatEn while held restarts the full REPEAT_DELAY.
  - Repeat and Press never coincide.
  - Repeat is registered, with no further latency beyond the above.
- Counts:
  - Counts_i increments by 1 at the edge after a cycle with Press[i] or Repeat[i] high.
  - Wraps from 2^EVT_W-1 to 0.
  - Release does not count.
  - Clear=1 zeroes all channels; Clear wins over a simultaneous increment (result 0).
- Channel independence: channels are fully independent; simultaneous events on several channels all take effect in the same cycle.

Test Plan (N=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, EVT_W=4):
- Bounce then hold: Buttons[0] toggles every 2 cycles for 20 cycles, then is held 1 from edge E0 -> Debounced[0] rises at E0+5; exactly one Press[0] pulse; Counts[3:0]=1; channel 1 unchanged.
- Glitch rejection and release:
  - While held, Buttons[0]=0 for 3 cycles -> no Release, Debounced stays 1.
  - Held 0 for 6 cycles -> one Release[0] pulse; Counts unchanged at 1.
- Auto-repeat:
  - RepeatEn=1, Buttons[1] held 30 cycles past Press (cycle P) -> Repeat[1] pulses at P+10, P+13, P+16, P+19, P+22, P+25, P+28; Counts[7:4]=8.
  - Dropping RepeatEn at P+14 -> no pulse at P+16.
- Wrap and clear:
  - 16 debounced presses on channel 0 -> Counts[3:0]=0.
  - Clear asserted in the same cycle as a Press -> counter reads 0 afterwards.
- Reset mid-operation:
  - Rst=1 for 1 cycle while the debounce counter is at 2 and the button is held -> all outputs 0.
  - Debounced rises DEBOUNCE_CYCLES+1 edges after the synchroniser re-fills; no stale Press.
- Simultaneous channels: both Buttons bits rise on the same edge -> Press[1:0]=2'b11 in the same cycle; Counts=8'h11.

Source files
------------

// File: rtl/multi_debounce.sv
// -----------------------------------------------------------------------------
// multi_debounce
//
// N independent pushbutton channels. Each channel has:
//   * a 2-FF synchroniser for the raw asynchronous button level,
//   * a symmetric debounce filter (press and release both filtered),
//   * registered one-cycle Press / Release pulses,
//   * an optional auto-repeat pulse generator while the button is held,
//   * a wrapping event counter that counts Press and Repeat pulses.
//
// Ports:
//   Clk        in   1        system clock, all logic on the rising edge
//   Rst        in   1        synchronous active-high reset of every register
//   Buttons    in   N        raw button levels, bit i = channel i
//   RepeatEn   in   1        global auto-repeat enable
//   Clear      in   1        synchronous clear of all event counters
//   Debounced  out  N        filtered button levels
//   Press      out  N        one-cycle pulse on a debounced rising edge
//   Release    out  N        one-cycle pulse on a debounced falling edge
//   Repeat     out  N        one-cycle auto-repeat pulse
//   Counts     out  N*EVT_W  event counters, channel i at [i*EVT_W +: EVT_W]
// -----------------------------------------------------------------------------
module multi_debounce #(
    parameter int N               = 5,
    parameter int DEBOUNCE_CYCLES = 131072,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int EVT_W           = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [N-1:0]       Buttons,
    input  logic               RepeatEn,
    input  logic               Clear,
    output logic [N-1:0]       Debounced,
    output logic [N-1:0]       Press,
    output logic [N-1:0]       Release,
    output logic [N-1:0]       Repeat,
    output logic [N*EVT_W-1:0] Counts
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // One repeat counter serves both phases, so size it for the longer one.
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = $clog2(RC_MAX);
    localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);

    typedef enum logic {
        RPT_DELAY = 1'b0,   // waiting for the first repeat after Press
        RPT_RATE  = 1'b1    // issuing repeats every REPEAT_PERIOD cycles
    } rpt_phase_t;

    // -------------------------------------------------------------------------
    // Two-stage synchroniser, shared vector for all channels.
    // -------------------------------------------------------------------------
    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;

    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge values of the others; blocking here would collapse the 2-FF chain.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= Buttons;
            r_sync2 <= r_sync1;
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel filter, edge pulses, auto-repeat and event counter.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [DB_W-1:0]  r_db_cnt;
        logic             r_deb;
        logic             r_press;
        logic             r_rel;

        rpt_phase_t       r_phase;
        rpt_phase_t       w_phase_nxt;
        logic [RC_W-1:0]  r_rc;
        logic [RC_W-1:0]  w_rc_nxt;
        logic             r_rep;
        logic             w_rep_nxt;

        logic [EVT_W-1:0] r_cnt;

        // Debounce filter: any cycle where the synchronised level agrees with
        // the filtered level restarts the count, so only an unbroken run of
        // DEBOUNCE_CYCLES disagreeing samples changes the output. Press and
        // Release are produced on the same edge that updates r_deb.
        always_ff @(posedge Clk) begin
            if (Rst) begin
                r_db_cnt <= '0;
                r_deb    <= 1'b0;
                r_press  <= 1'b0;
                r_rel    <= 1'b0;
            end else begin
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                if (r_sync2[g] == r_deb) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_LAST) begin
                    r_deb    <= r_sync2[g];
                    r_db_cnt <= '0;
                    r_press  <= r_sync2[g];
                    r_rel    <= ~r_sync2[g];
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end
        end

        // Auto-repeat next-state logic. While released or disabled the counter
        // is held at zero in DELAY; r_deb is still 0 on the Press edge, so the
        // Press cycle always starts with rc=0 and a full REPEAT_DELAY ahead.
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        always_comb begin
            w_phase_nxt = r_phase;
            w_rc_nxt    = r_rc;
            w_rep_nxt   = 1'b0;
            if (!r_deb || !RepeatEn) begin
                w_phase_nxt = RPT_DELAY;
                w_rc_nxt    = '0;
            end else begin
                case (r_phase)
                    RPT_DELAY: begin
                        if (r_rc == RD_LAST) begin
                            w_rep_nxt   = 1'b1;
                            w_rc_nxt    = '0;
                            w_phase_nxt = RPT_RATE;
                        end else begin
                            w_rc_nxt = r_rc + RC_W'(1);
                        end
                    end
                    RPT_RATE: begin
                        if (r_rc == RP_LAST) begin
                            w_rep_nxt = 1'b1;
                            w_rc_nxt  = '0;
                        end else begin
                            w_rc_nxt = r_rc + RC_W'(1);
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge Clk) begin
            if (Rst) begin
                r_phase <= RPT_DELAY;
                r_rc    <= '0;
                r_rep   <= 1'b0;
            end else begin
                r_phase <= w_phase_nxt;
                r_rc    <= w_rc_nxt;
                r_rep   <= w_rep_nxt;
            end
        end

        // Event counter: counts the cycle after a Press or Repeat pulse.
        // Clear takes precedence over a coincident increment.
        always_ff @(posedge Clk) begin
            if (Rst || Clear) begin
                r_cnt <= '0;
            end else if (r_press || r_rep) begin
                r_cnt <= r_cnt + EVT_W'(1);
            end
        end

        assign Debounced[g]               = r_deb;
        assign Press[g]                   = r_press;
        assign Release[g]                 = r_rel;
        assign Repeat[g]                  = r_rep;
        assign Counts[g*EVT_W +: EVT_W]   = r_cnt;
    end

endmodule

// File: tb/tb_multi_debounce.sv
// -----------------------------------------------------------------------------
// tb_multi_debounce
//
// Self-checking bench for multi_debounce with small parameters. A reference
// model, written from the behavioural rules (sample history windows and
// held-run lengths rather than counters/FSM), predicts every output each clock
// and pushes it into a scoreboard queue; a monitor pops and compares on the
// falling edge. Directed sequences cover bounce, glitches, auto-repeat, wrap,
// clear, mid-operation reset and simultaneous channels, followed by random
// stimulus.
// -----------------------------------------------------------------------------
module tb_multi_debounce;

    localparam int N  = 2;
    localparam int DC = 4;    // DEBOUNCE_CYCLES
    localparam int RD = 10;   // REPEAT_DELAY
    localparam int RP = 3;    // REPEAT_PERIOD
    localparam int EW = 4;    // EVT_W

    logic            Clk;
    logic            Rst;
    logic [N-1:0]    Buttons;
    logic            RepeatEn;
    logic            Clear;
    logic [N-1:0]    Debounced;
    logic [N-1:0]    Press;
    logic [N-1:0]    Release;
    logic [N-1:0]    Repeat;
    logic [N*EW-1:0] Counts;

    multi_debounce #(
        .N               (N),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .EVT_W           (EW)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Buttons   (Buttons),
        .RepeatEn  (RepeatEn),
        .Clear     (Clear),
        .Debounced (Debounced),
        .Press     (Press),
        .Release   (Release),
        .Repeat    (Repeat),
        .Counts    (Counts)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [N-1:0]    deb;
        logic [N-1:0]    press;
        logic [N-1:0]    rel;
        logic [N-1:0]    rep;
        logic [N*EW-1:0] counts;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] m_raw_q[$];   // raw samples since reset (last two kept)
    logic [N-1:0] m_s_hist[$];  // last DC synchronised samples
    logic [N-1:0] m_deb;
    logic [N-1:0] m_press;
    logic [N-1:0] m_rel;
    logic [N-1:0] m_rep;
    int           m_run[N];     // consecutive cycles held with repeat enabled
    int           m_cnt[N];

    task automatic model_step();
        logic [N-1:0] s_now;
        logic [N-1:0] deb_old;
        logic [N-1:0] press_old;
        logic [N-1:0] rep_old;
        logic         all_differ;
        exp_t         e;
        if (Rst) begin
            m_raw_q.delete();
            m_s_hist.delete();
            m_deb   = '0;
            m_press = '0;
            m_rel   = '0;
            m_rep   = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0;
                m_cnt[i] = 0;
            end
        end else begin
            deb_old   = m_deb;
            press_old = m_press;
            rep_old   = m_rep;
            // Synchronised level is the raw input from two edges ago.
            s_now = (m_raw_q.size() >= 2) ? m_raw_q[m_raw_q.size()-2] : '0;
            m_raw_q.push_back(Buttons);
            if (m_raw_q.size() > 2) void'(m_raw_q.pop_front());
            m_s_hist.push_back(s_now);
            if (m_s_hist.size() > DC) void'(m_s_hist.pop_front());
            for (int i = 0; i < N; i++) begin
                // Level changes once the last DC samples all disagree with it.
                all_differ = (m_s_hist.size() == DC);
                for (int h = 0; h < m_s_hist.size(); h++)
                    if (m_s_hist[h][i] == deb_old[i]) all_differ = 1'b0;
                if (all_differ) m_deb[i] = ~deb_old[i];
                m_press[i] = m_deb[i] & ~deb_old[i];
                m_rel[i]   = ~m_deb[i] & deb_old[i];
                // Repeat fires when the held-and-enabled run reaches RD, then
                // every RP cycles.
                if (deb_old[i] && RepeatEn) m_run[i]++;
                else                        m_run[i] = 0;
                m_rep[i] = (m_run[i] >= RD) && (((m_run[i] - RD) % RP) == 0);
                if (Clear)                           m_cnt[i] = 0;
                else if (press_old[i] || rep_old[i]) m_cnt[i] = (m_cnt[i] + 1) % (1 << EW);
            end
        end
        e.deb   = m_deb;
        e.press = m_press;
        e.rel   = m_rel;
        e.rep   = m_rep;
        for (int i = 0; i < N; i++) e.counts[i*EW +: EW] = EW'(m_cnt[i]);
        exp_q.push_back(e);
    endtask

    always @(posedge Clk) model_step();

    // -------------------------------------------------------------------------
    // Monitor: compares DUT outputs with the predicted entry each cycle.
    // -------------------------------------------------------------------------
    task automatic monitor_step();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_debounced", 32'(Debounced), 32'(e.deb));
            check("sb_press",     32'(Press),     32'(e.press));
            check("sb_release",   32'(Release),   32'(e.rel));
            check("sb_repeat",    32'(Repeat),    32'(e.rep));
            check("sb_counts",    32'(Counts),    32'(e.counts));
        end
    endtask

    always @(negedge Clk) monitor_step();

    // -------------------------------------------------------------------------
    // Stimulus (inputs change on the falling edge) with directed spot checks.
    // -------------------------------------------------------------------------
    initial begin : stim
        logic [N-1:0] flip;
        int           hold;
        Rst      = 1'b1;
        Buttons  = '0;
        RepeatEn = 1'b0;
        Clear    = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_debounced", 32'(Debounced), 0);
        check("rst_pulses",    32'({Press, Release, Repeat}), 0);
        check("rst_counts",    32'(Counts), 0);
        Rst = 1'b0;

        // Bounce, then hold high: Debounced rises 5 edges after the first sample.
        for (int c = 0; c < 20; c++) begin
            Buttons[0] = ((c / 2) % 2) == 0;
            @(negedge Clk);
        end
        Buttons[0] = 1'b1;
        repeat (5) @(negedge Clk);
        check("bounce_deb_before", 32'(Debounced), 0);
        @(negedge Clk);
        check("bounce_deb_rise", 32'(Debounced), 2'b01);
        check("bounce_press",    32'(Press), 2'b01);
        @(negedge Clk);
        check("bounce_press_once", 32'(Press), 0);
        repeat (4) @(negedge Clk);
        check("bounce_count", 32'(Counts), 8'h01);

        // Three-cycle glitch is rejected; six cycles low releases.
        Buttons[0] = 1'b0;
        repeat (3) @(negedge Clk);
        Buttons[0] = 1'b1;
        repeat (10) @(negedge Clk);
        check("glitch_deb_held", 32'(Debounced), 2'b01);
        Buttons[0] = 1'b0;
        repeat (12) @(negedge Clk);
        check("release_deb", 32'(Debounced), 0);
        check("release_count", 32'(Counts), 8'h01);

        // Auto-repeat on channel 1: pulses at P+10,13,...,28, cut off at P+29.
        RepeatEn   = 1'b1;
        Buttons[1] = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge Clk);
            if (j == 16) check("repeat_first", 32'(Repeat), 2'b10);
            if (j == 17) check("repeat_gap",   32'(Repeat), 0);
            if (j == 35) RepeatEn = 1'b0;
        end
        check("repeat_count", 32'(Counts), 8'h81);
        Buttons[1] = 1'b0;
        repeat (12) @(negedge Clk);

        // Dropping RepeatEn at P+14 suppresses P+16 and restarts the delay.
        RepeatEn   = 1'b1;
        Buttons[1] = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            @(negedge Clk);
            if (j == 16) check("rpt2_p10", 32'(Repeat[1]), 1);
            if (j == 19) check("rpt2_p13", 32'(Repeat[1]), 1);
            if (j == 20) RepeatEn = 1'b0;
            if (j == 21) RepeatEn = 1'b1;
            if (j == 22) check("rpt2_no_p16", 32'(Repeat[1]), 0);
            if (j == 31) check("rpt2_restart_p25", 32'(Repeat[1]), 1);
        end
        RepeatEn   = 1'b0;
        Buttons[1] = 1'b0;
        repeat (12) @(negedge Clk);
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        @(negedge Clk);
        check("clear_all", 32'(Counts), 0);

        // Sixteen presses wrap the 4-bit counter.
        for (int k = 0; k < 16; k++) begin
            Buttons[0] = 1'b1;
            repeat (8) @(negedge Clk);
            Buttons[0] = 1'b0;
            repeat (8) @(negedge Clk);
            if (k == 14) check("wrap_15", 32'(Counts), 8'h0f);
        end
        check("wrap_0", 32'(Counts), 0);

        // Clear coinciding with Press wins.
        Buttons[0] = 1'b1;
        repeat (14) @(negedge Clk);
        check("pre_clear_count", 32'(Counts), 8'h01);
        Buttons[0] = 1'b0;
        repeat (12) @(negedge Clk);
        Buttons[0] = 1'b1;
        repeat (6) @(negedge Clk);
        check("clear_press_seen", 32'(Press), 2'b01);
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        repeat (2) @(negedge Clk);
        check("clear_beats_press", 32'(Counts), 0);

        // Reset with the debounce counter at 2 discards progress.
        Buttons[0] = 1'b0;
        repeat (12) @(negedge Clk);
        Buttons[0] = 1'b1;
        repeat (4) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check("midrst_outputs", 32'({Debounced, Press, Release, Repeat}), 0);
        check("midrst_counts",  32'(Counts), 0);
        repeat (5) @(negedge Clk);
        check("midrst_deb_before", 32'(Debounced), 0);
        @(negedge Clk);
        check("midrst_deb_rise", 32'(Debounced), 2'b01);
        check("midrst_press",    32'(Press), 2'b01);

        // Both channels rise together.
        Buttons = '0;
        repeat (12) @(negedge Clk);
        Clear = 1'b1;
        @(negedge Clk);
        Clear   = 1'b0;
        Buttons = 2'b11;
        repeat (6) @(negedge Clk);
        check("simul_press", 32'(Press), 2'b11);
        repeat (2) @(negedge Clk);
        check("simul_counts", 32'(Counts), 8'h11);

        // Random phase: the scoreboard checks every cycle.
        for (int k = 0; k < 400; k++) begin
            flip     = N'($urandom_range(1, (1 << N) - 1));
            Buttons  = Buttons ^ flip;
            RepeatEn = ($urandom_range(0, 3) != 0);
            Clear    = ($urandom_range(0, 40) == 0);
            Rst      = ($urandom_range(0, 150) == 0);
            hold     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                @(negedge Clk);
                Clear = 1'b0;
                Rst   = 1'b0;
            end
        end

        repeat (3) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
